// File: rtl/pbkdf2_multiblock.sv
// pbkdf2_multiblock: PBKDF2 block sequencer driving an external HMAC-SHA256 PRF.
// Emits T_1..T_n, one 256-bit derived-key block per output beat.
module pbkdf2_multiblock #(
    parameter int ITER_W     = 32,
    parameter int MAX_BLOCKS = 4,
    parameter int BLK_W      = $clog2(MAX_BLOCKS + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ITER_W-1:0] iters_i,
    input  logic [511:0]      pass_i,
    input  logic [511:0]      salt_i,
    input  logic [6:0]        salt_len_i,
    input  logic [BLK_W-1:0]  nblocks_i,
    input  logic              abort_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [255:0]      dk_o,
    output logic [BLK_W-1:0]  blk_idx_o,
    output logic              last_o,
    output logic              err_o,
    output logic              prf_valid_o,
    input  logic              prf_ready_i,
    output logic [511:0]      prf_key_o,
    output logic [511:0]      prf_msg_o,
    output logic [6:0]        prf_msg_len_o,
    input  logic              prf_valid_i,
    output logic              prf_ready_o,
    input  logic [255:0]      prf_hash_i
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, OUT, DRAIN} state_t;
    state_t state, state_nx;
    logic [ITER_W-1:0] iters_q, j;
    logic [511:0]      pass_q, salt_q, msg_first;
    logic [6:0]        salt_len_q;
    logic [9:0]        shift;
    logic [BLK_W-1:0]  nblocks_q, blk;
    logic [255:0]      t_q, u_q;
    logic              err_q, legal, first_iter, last_iter, last_beat, rsp_take;

    assign legal      = iters_i != '0 && nblocks_i != '0 && nblocks_i <= BLK_W'(MAX_BLOCKS)
                        && salt_len_i <= 7'd60;
    assign first_iter = j == ITER_W'(1);
    assign last_iter  = j == iters_q;
    assign last_beat  = err_q || blk == nblocks_q;
    assign rsp_take   = state == WAIT && prf_valid_i && !abort_i;
    // Salt bytes beyond salt_len are masked off; the block index lands right after the salt.
    assign shift      = {salt_len_q, 3'b000};
    assign msg_first  = (salt_q & ~({512{1'b1}} >> shift)) | ({32'(blk), 480'b0} >> shift);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        in_ready_o  = 1'b0;
        prf_valid_o = 1'b0;
        prf_ready_o = 1'b0;
        out_valid_o = 1'b0;
        case (state)
            IDLE: begin
                in_ready_o = 1'b1;
                if (!abort_i && in_valid_i) state_nx = legal ? REQ : OUT;
            end
            REQ: begin
                prf_valid_o = 1'b1;
                if (abort_i) state_nx = prf_ready_i ? DRAIN : IDLE;
                else if (prf_ready_i) state_nx = WAIT;
            end
            WAIT: begin
                prf_ready_o = 1'b1;
                // A response landing in the abort cycle is already consumed, so nothing is left to drain.
                if (abort_i) state_nx = prf_valid_i ? IDLE : DRAIN;
                else if (prf_valid_i) state_nx = last_iter ? OUT : REQ;
            end
            OUT: begin
                out_valid_o = 1'b1;
                if (abort_i) state_nx = IDLE;
                else if (out_ready_i) state_nx = last_beat ? IDLE : REQ;
            end
            DRAIN: begin
                prf_ready_o = 1'b1;
                if (prf_valid_i) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            iters_q    <= '0;
            pass_q     <= '0;
            salt_q     <= '0;
            salt_len_q <= '0;
            nblocks_q  <= '0;
            err_q      <= 1'b0;
            blk        <= '0;
            j          <= '0;
            t_q        <= '0;
            u_q        <= '0;
        end else begin
            if (in_valid_i && in_ready_o) begin
                iters_q    <= iters_i;
                pass_q     <= pass_i;
                salt_q     <= salt_i;
                salt_len_q <= salt_len_i;
                nblocks_q  <= nblocks_i;
                err_q      <= !legal;
                blk        <= BLK_W'(1);
                j          <= ITER_W'(1);
            end
            if (rsp_take) begin
                u_q <= prf_hash_i;
                t_q <= first_iter ? prf_hash_i : t_q ^ prf_hash_i;
                if (!last_iter) j <= j + ITER_W'(1);
            end
            if (state == OUT && out_ready_i && !abort_i && !last_beat) begin
                blk <= blk + BLK_W'(1);
                j   <= ITER_W'(1);
            end
        end
    end

    assign prf_key_o     = pass_q;
    assign prf_msg_o     = state != REQ ? '0 : first_iter ? msg_first : {u_q, 256'b0};
    assign prf_msg_len_o = state != REQ ? '0 : first_iter ? salt_len_q + 7'd4 : 7'd32;
    assign dk_o          = out_valid_o && !err_q ? t_q : '0;
    assign blk_idx_o     = out_valid_o && !err_q ? blk : '0;
    assign last_o        = out_valid_o && last_beat;
    assign err_o         = out_valid_o && err_q;
endmodule

// File: tb/tb_pbkdf2_multiblock.sv
// tb_pbkdf2_multiblock: randomized bench with an HMAC-SHA256 PRF responder and a
// direct PBKDF2 reference model computed from the algorithm definition.
module tb_pbkdf2_multiblock;
    localparam int ITER_W = 32, MAX_BLOCKS = 4, BLK_W = 3;
    localparam logic [511:0] KAT_PASS = {64'h70617373776f7264, 448'b0};
    localparam logic [511:0] KAT_SALT = {32'h73616c74, 480'b0};
    localparam logic [255:0] KAT_C1 = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
    localparam logic [255:0] KAT_C2 = 256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43;
    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    typedef struct {
        logic [255:0] dk;
        logic [2:0]   idx;
        logic         last;
        logic         err;
    } beat_t;

    logic              clk = 1'b0, rst_ni = 1'b0;
    logic              in_valid_i = 1'b0, in_ready_o;
    logic [ITER_W-1:0] iters_i = '0;
    logic [511:0]      pass_i = '0, salt_i = '0;
    logic [6:0]        salt_len_i = '0;
    logic [BLK_W-1:0]  nblocks_i = '0;
    logic              abort_i = 1'b0, out_valid_o, out_ready_i = 1'b0;
    logic [255:0]      dk_o;
    logic [BLK_W-1:0]  blk_idx_o;
    logic              last_o, err_o, prf_valid_o, prf_ready_i = 1'b0;
    logic [511:0]      prf_key_o, prf_msg_o;
    logic [6:0]        prf_msg_len_o;
    logic              prf_valid_i = 1'b0, prf_ready_o;
    logic [255:0]      prf_hash_i = '0;
    int                n_checks = 0, n_fail = 0;

    pbkdf2_multiblock #(.ITER_W(ITER_W), .MAX_BLOCKS(MAX_BLOCKS), .BLK_W(BLK_W)) dut (
        .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .iters_i(iters_i), .pass_i(pass_i), .salt_i(salt_i), .salt_len_i(salt_len_i),
        .nblocks_i(nblocks_i), .abort_i(abort_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .dk_o(dk_o), .blk_idx_o(blk_idx_o), .last_o(last_o),
        .err_o(err_o), .prf_valid_o(prf_valid_o), .prf_ready_i(prf_ready_i),
        .prf_key_o(prf_key_o), .prf_msg_o(prf_msg_o), .prf_msg_len_o(prf_msg_len_o),
        .prf_valid_i(prf_valid_i), .prf_ready_o(prf_ready_o), .prf_hash_i(prf_hash_i));

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256(input logic [1023:0] data, input int len);
        logic [7:0]  p [192];
        logic [31:0] h [8];
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
        logic [63:0] bits;
        int nb;
        nb = (len + 8) / 64 + 1;
        bits = 64'(len) * 64'd8;
        for (int i = 0; i < 192; i++) p[i] = 8'h00;
        for (int i = 0; i < len; i++) p[i] = data[1023 - 8*i -: 8];
        p[len] = 8'h80;
        for (int k = 0; k < 8; k++) p[nb*64 - 1 - k] = bits[8*k +: 8];
        h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int bk = 0; bk < nb; bk++) begin
            for (int t = 0; t < 16; t++)
                w[t] = {p[bk*64 + 4*t], p[bk*64 + 4*t + 1], p[bk*64 + 4*t + 2], p[bk*64 + 4*t + 3]};
            for (int t = 16; t < 64; t++) begin
                s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
            {a, b, c, d, e, f, g, hh} = {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
            for (int t = 0; t < 64; t++) begin
                t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
                t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
                {hh, g, f, e, d, c, b, a} = {g, f, e, d + t1, c, b, a, t1 + t2};
            end
            h[0] += a; h[1] += b; h[2] += c; h[3] += d;
            h[4] += e; h[5] += f; h[6] += g; h[7] += hh;
        end
        return {h[0], h[1], h[2], h[3], h[4], h[5], h[6], h[7]};
    endfunction

    // The 512-bit key is already the zero-padded HMAC block key.
    function automatic logic [255:0] hmac(input logic [511:0] key, input logic [511:0] msg, input int len);
        logic [255:0] ih;
        ih = sha256({key ^ {64{8'h36}}, msg}, 64 + len);
        return sha256({key ^ {64{8'h5c}}, ih, 256'b0}, 96);
    endfunction

    function automatic logic [511:0] salt_index_msg(input logic [511:0] salt, input int slen, input int b);
        logic [511:0] m;
        logic [31:0]  bb;
        m = '0;
        bb = 32'(b);
        for (int i = 0; i < slen; i++) m[511 - 8*i -: 8] = salt[511 - 8*i -: 8];
        for (int k = 0; k < 4; k++) m[511 - 8*(slen + k) -: 8] = bb[31 - 8*k -: 8];
        return m;
    endfunction

    task automatic run_job(input logic [511:0] pass, input logic [511:0] salt, input int slen,
                           input int iters, input int nblk, input bit stall,
                           output logic [511:0] msg1, output int len1, output logic [511:0] msg2,
                           output int len2, output logic [255:0] dk1, output int npv,
                           output int nacc, output int nbeats);
        logic [511:0] rq_msg[$];
        int           rq_len[$];
        beat_t        eb[$];
        logic [511:0] m;
        logic [255:0] u, t, hash;
        int           l, cyc, dly, hold;
        bit           legal, done, first, pend, resp_sent;
        msg1 = '0; msg2 = '0; len1 = 0; len2 = 0; dk1 = '0; npv = 0; nacc = 0; nbeats = 0;
        u = '0; t = '0; hash = '0;
        legal = iters >= 1 && nblk >= 1 && nblk <= MAX_BLOCKS && slen <= 60;
        if (!legal) eb.push_back('{256'b0, 3'd0, 1'b1, 1'b1});
        else for (int b = 1; b <= nblk; b++) begin
            for (int j = 1; j <= iters; j++) begin
                if (j == 1) begin m = salt_index_msg(salt, slen, b); l = slen + 4; end
                else begin m = {u, 256'b0}; l = 32; end
                rq_msg.push_back(m);
                rq_len.push_back(l);
                u = hmac(pass, m, l);
                t = (j == 1) ? u : t ^ u;
            end
            eb.push_back('{t, 3'(b), b == nblk, 1'b0});
        end
        @(negedge clk);
        in_valid_i = 1'b1; iters_i = 32'(iters); pass_i = pass; salt_i = salt;
        salt_len_i = 7'(slen); nblocks_i = 3'(nblk);
        n_checks++;
        if (in_ready_o !== 1'b1) begin n_fail++; $display("FAIL job_accept: in_ready_o=%b want 1", in_ready_o); end
        @(negedge clk);
        in_valid_i = 1'b0;
        done = 0; first = 1; pend = 0; resp_sent = 0; cyc = 0; dly = 0; hold = 0;
        while (!done && cyc < 3000) begin
            prf_valid_i = 1'b0; prf_ready_i = 1'b0; out_ready_i = 1'b0;
            if (first) begin
                n_checks++;
                if ((legal ? prf_valid_o : out_valid_o) !== 1'b1) begin
                    n_fail++; $display("FAIL start_latency: prf_valid_o=%b out_valid_o=%b legal=%0d", prf_valid_o, out_valid_o, legal);
                end
                first = 0;
            end
            if (resp_sent) begin
                n_checks++;
                if ((prf_valid_o | out_valid_o) !== 1'b1) begin
                    n_fail++; $display("FAIL resp_latency: prf_valid_o=%b out_valid_o=%b want one high", prf_valid_o, out_valid_o);
                end
                resp_sent = 0;
            end
            n_checks++;
            if (prf_key_o !== pass) begin n_fail++; $display("FAIL prf_key: got %h want %h", prf_key_o, pass); end
            if (prf_valid_o === 1'b1) begin
                npv++;
                n_checks++;
                if (rq_msg.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_req: msg %h len %0d", prf_msg_o, prf_msg_len_o);
                    done = 1;
                end else if (prf_msg_o !== rq_msg[0] || int'(prf_msg_len_o) != rq_len[0]) begin
                    n_fail++; $display("FAIL req_msg: got %h/%0d want %h/%0d", prf_msg_o, prf_msg_len_o, rq_msg[0], rq_len[0]);
                end
                if (!done && (!stall || $urandom_range(1, 0) == 1)) begin
                    prf_ready_i = 1'b1;
                    if (nacc == 0) begin msg1 = prf_msg_o; len1 = int'(prf_msg_len_o); end
                    if (nacc == 1) begin msg2 = prf_msg_o; len2 = int'(prf_msg_len_o); end
                    hash = hmac(pass, prf_msg_o, int'(prf_msg_len_o));
                    void'(rq_msg.pop_front());
                    void'(rq_len.pop_front());
                    nacc++;
                    pend = 1;
                    dly = stall ? int'($urandom_range(4, 0)) : 0;
                end
            end else if (pend) begin
                if (dly == 0) begin
                    n_checks++;
                    if (prf_ready_o !== 1'b1) begin n_fail++; $display("FAIL wait_ready: prf_ready_o=%b want 1", prf_ready_o); end
                    prf_valid_i = 1'b1; prf_hash_i = hash; pend = 0; resp_sent = 1;
                end else dly--;
            end
            if (out_valid_o === 1'b1) begin
                n_checks++;
                if (eb.size() == 0) begin
                    n_fail++; $display("FAIL unexpected_beat: dk %h", dk_o);
                    done = 1;
                end else if ({dk_o, blk_idx_o, last_o, err_o} !== {eb[0].dk, eb[0].idx, eb[0].last, eb[0].err}) begin
                    n_fail++;
                    $display("FAIL out_beat: got dk=%h idx=%0d last=%b err=%b want dk=%h idx=%0d last=%b err=%b",
                             dk_o, blk_idx_o, last_o, err_o, eb[0].dk, eb[0].idx, eb[0].last, eb[0].err);
                end
                if (!done && (!stall || (hold >= 10 && $urandom_range(1, 0) == 1))) begin
                    out_ready_i = 1'b1;
                    if (nbeats == 0) dk1 = dk_o;
                    nbeats++;
                    done = last_o === 1'b1;
                    void'(eb.pop_front());
                    hold = 0;
                end else hold++;
            end
            @(negedge clk);
            cyc++;
        end
        prf_valid_i = 1'b0; prf_ready_i = 1'b0; out_ready_i = 1'b0;
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL job_timeout: no final beat after %0d cycles", cyc); end
        n_checks++;
        if (in_ready_o !== 1'b1 || rq_msg.size() != 0 || eb.size() != 0) begin
            n_fail++; $display("FAIL job_end: in_ready_o=%b pending_reqs=%0d pending_beats=%0d want 1/0/0", in_ready_o, rq_msg.size(), eb.size());
        end
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready_o, out_valid_o, prf_valid_o, prf_ready_o, last_o, err_o} !== 6'b100000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 100000", {in_ready_o, out_valid_o, prf_valid_o, prf_ready_o, last_o, err_o});
        end
        n_checks++;
        if (dk_o !== '0 || blk_idx_o !== '0 || prf_key_o !== '0 || prf_msg_o !== '0 || prf_msg_len_o !== '0) begin
            n_fail++; $display("FAIL reset_data: dk %h idx %0d key %h msg %h len %0d want all 0", dk_o, blk_idx_o, prf_key_o, prf_msg_o, prf_msg_len_o);
        end
    endtask

    task automatic test_kat;
        logic [511:0] m1, m2;
        logic [255:0] dk;
        int l1, l2, npv, nacc, nb;
        run_job(KAT_PASS, KAT_SALT, 4, 1, 1, 0, m1, l1, m2, l2, dk, npv, nacc, nb);
        n_checks++;
        if (dk !== KAT_C1 || m1 !== {64'h73616c7400000001, 448'b0} || l1 != 8 || nb != 1) begin
            n_fail++; $display("FAIL kat_c1: dk %h msg %h len %0d beats %0d want %h len 8 beats 1", dk, m1[511:448], l1, nb, KAT_C1);
        end
        run_job(KAT_PASS, KAT_SALT, 4, 2, 1, 0, m1, l1, m2, l2, dk, npv, nacc, nb);
        n_checks++;
        if (dk !== KAT_C2 || nacc != 2 || l2 != 32) begin
            n_fail++; $display("FAIL kat_c2: dk %h reqs %0d len2 %0d want %h reqs 2 len2 32", dk, nacc, l2, KAT_C2);
        end
        run_job(KAT_PASS, KAT_SALT, 4, 1, 2, 0, m1, l1, m2, l2, dk, npv, nacc, nb);
        n_checks++;
        if (dk !== KAT_C1 || nb != 2 || m2 !== {64'h73616c7400000002, 448'b0}) begin
            n_fail++; $display("FAIL kat_two_blocks: dk %h beats %0d msg2 %h want beats 2 msg2 73616c7400000002", dk, nb, m2[511:448]);
        end
    endtask

    task automatic test_stall;
        logic [511:0] m1, m2;
        logic [255:0] dk;
        int l1, l2, npv, nacc, nb;
        run_job(KAT_PASS, KAT_SALT, 4, 1, 1, 1, m1, l1, m2, l2, dk, npv, nacc, nb);
        n_checks++;
        if (dk !== KAT_C1) begin n_fail++; $display("FAIL stall_kat: dk %h want %h", dk, KAT_C1); end
    endtask

    task automatic test_illegal;
        int cases [4][3] = '{'{0, 4, 1}, '{1, 61, 1}, '{1, 4, 0}, '{1, 4, 5}};
        logic [511:0] m1, m2;
        logic [255:0] dk;
        int l1, l2, npv, nacc, nb;
        for (int i = 0; i < 4; i++) begin
            run_job(KAT_PASS, KAT_SALT, cases[i][1], cases[i][0], cases[i][2], 0, m1, l1, m2, l2, dk, npv, nacc, nb);
            n_checks++;
            if (npv != 0 || nb != 1) begin
                n_fail++; $display("FAIL illegal_%0d: prf_valid cycles %0d beats %0d want 0 and 1", i, npv, nb);
            end
        end
    endtask

    task automatic test_abort;
        logic [511:0] m1, m2;
        logic [255:0] dk;
        int l1, l2, npv, nacc, nb;
        bit saw_out;
        @(negedge clk);
        in_valid_i = 1'b1; iters_i = 32'd3; pass_i = KAT_PASS; salt_i = KAT_SALT; salt_len_i = 7'd4; nblocks_i = 3'd1;
        @(negedge clk);
        in_valid_i = 1'b0; prf_ready_i = 1'b1;
        @(negedge clk);
        prf_ready_i = 1'b0; abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        n_checks++;
        if (prf_ready_o !== 1'b1 || in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_wait_drain: prf_ready_o=%b in_ready_o=%b want 1/0", prf_ready_o, in_ready_o);
        end
        saw_out = 0;
        repeat (4) begin @(negedge clk); saw_out |= out_valid_o; end
        prf_valid_i = 1'b1; prf_hash_i = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        prf_valid_i = 1'b0;
        saw_out |= out_valid_o;
        n_checks++;
        if (in_ready_o !== 1'b1 || saw_out || prf_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_wait_idle: in_ready_o=%b out_seen=%b prf_valid_o=%b want 1/0/0", in_ready_o, saw_out, prf_valid_o);
        end
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0; abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1 || prf_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_req: in_ready_o=%b prf_valid_o=%b want 1/0", in_ready_o, prf_valid_o);
        end
        in_valid_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0; abort_i = 1'b1; prf_ready_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0; prf_ready_i = 1'b0;
        n_checks++;
        if (prf_ready_o !== 1'b1 || in_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_req_taken: prf_ready_o=%b in_ready_o=%b want 1/0", prf_ready_o, in_ready_o);
        end
        prf_valid_i = 1'b1;
        @(negedge clk);
        prf_valid_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL abort_req_idle: in_ready_o=%b out_valid_o=%b want 1/0", in_ready_o, out_valid_o);
        end
        run_job(KAT_PASS, KAT_SALT, 4, 1, 1, 0, m1, l1, m2, l2, dk, npv, nacc, nb);
        n_checks++;
        if (dk !== KAT_C1) begin n_fail++; $display("FAIL abort_next_job: dk %h want %h", dk, KAT_C1); end
    endtask

    task automatic test_reset_midjob;
        logic [511:0] m1, m2;
        logic [255:0] dk;
        int l1, l2, npv, nacc, nb;
        @(negedge clk);
        in_valid_i = 1'b1; iters_i = 32'd2; pass_i = KAT_PASS; salt_i = KAT_SALT; salt_len_i = 7'd4; nblocks_i = 3'd1;
        @(negedge clk);
        in_valid_i = 1'b0; prf_ready_i = 1'b1;
        @(negedge clk);
        prf_ready_i = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        n_checks++;
        if (in_ready_o !== 1'b1 || prf_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_async: in_ready_o=%b prf_ready_o=%b want 1/0", in_ready_o, prf_ready_o);
        end
        @(negedge clk);
        rst_ni = 1'b1; prf_valid_i = 1'b1; prf_hash_i = '1;
        n_checks++;
        if (prf_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_stale_rsp: prf_ready_o=%b want 0", prf_ready_o); end
        @(negedge clk);
        prf_valid_i = 1'b0;
        n_checks++;
        if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: in_ready_o=%b out_valid_o=%b want 1/0", in_ready_o, out_valid_o);
        end
        run_job(KAT_PASS, KAT_SALT, 4, 2, 1, 1, m1, l1, m2, l2, dk, npv, nacc, nb);
        n_checks++;
        if (dk !== KAT_C2) begin n_fail++; $display("FAIL reset_next_job: dk %h want %h", dk, KAT_C2); end
    endtask

    task automatic test_random;
        logic [511:0] pass, salt, m1, m2;
        logic [255:0] dk;
        int l1, l2, npv, nacc, nb;
        for (int n = 0; n < 8; n++) begin
            for (int w = 0; w < 16; w++) begin pass[32*w +: 32] = $urandom; salt[32*w +: 32] = $urandom; end
            run_job(pass, salt, int'($urandom_range(60, 0)), int'($urandom_range(3, 1)),
                    int'($urandom_range(MAX_BLOCKS, 1)), bit'($urandom_range(1, 0)),
                    m1, l1, m2, l2, dk, npv, nacc, nb);
        end
    endtask

    initial begin
        test_reset;
        test_kat;
        test_stall;
        test_illegal;
        test_abort;
        test_reset_midjob;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pbkdf2_multiblock.md
PBKDF2_MULTIBLOCK -- requirements
Module: pbkdf2_multiblock

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ITER_W, 32, iteration-count width
  MAX_BLOCKS, 4, maximum 256-bit output blocks per job (>=1)
  BLK_W, $clog2(MAX_BLOCKS+1), block-count/index width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk_i  in  1  sole clock
  rst_ni  in  1  reset, asynchronous assert, active-low
  in_valid_i / in_ready_o  in/out  1  job handshake
  iters_i  in  ITER_W  iteration count c
  pass_i  in  512  HMAC key, passed unchanged to PRF
  salt_i  in  512  salt; byte 0 in [511:504]
  salt_len_i  in  7  salt length, bytes
  nblocks_i  in  BLK_W  output blocks requested
  abort_i  in  1  cancel current job
  out_valid_o / out_ready_i  out/in  1  result handshake
  dk_o  out  256  derived-key block T_i
  blk_idx_o  out  BLK_W  1-based index of dk_o
  last_o  out  1  final beat of job
  err_o  out  1  job rejected
  prf_valid_o / prf_ready_i  out/in  1  PRF request handshake
  prf_key_o, prf_msg_o  out  512  PRF key, message
  prf_msg_len_o  out  7  PRF message length, bytes
  prf_valid_i / prf_ready_o  in/out  1  PRF response handshake
  prf_hash_i  in  256  PRF (HMAC-SHA256) output

Function
REQ-003 A transfer SHALL occur on any valid&ready cycle; inputs SHALL be registered on the in transfer.
REQ-004 States SHALL be IDLE, REQ, WAIT, OUT, DRAIN; in_ready_o=1 only in IDLE.
REQ-005 IDLE->REQ on in transfer with legal job (iters>=1, 1<=nblocks<=MAX_BLOCKS, salt_len<=60); blk=1, j=1.
REQ-006 Illegal job SHALL go IDLE->OUT, single beat: err_o=1, last_o=1, dk_o=0, blk_idx_o=0; no PRF request.
REQ-007 REQ: prf_valid_o=1, inputs stable until prf_ready_i; transfer -> WAIT.
REQ-008 For j=1, prf_msg_o SHALL be salt bytes then 32-bit big-endian blk, remaining bits 0; prf_msg_len_o=salt_len+4.
REQ-009 For j>1, prf_msg_o[511:256]=U(j-1), [255:0]=0, prf_msg_len_o=32.
REQ-010 WAIT: prf_ready_o=1; on prf_valid_i, U register<=prf_hash_i; T<=prf_hash_i if j=1 else T^prf_hash_i.
REQ-011 On response: j==iters -> OUT; else j<=j+1 (ITER_W bits, no wrap since j<=iters) -> REQ.
REQ-012 OUT: out_valid_o=1, dk_o=T, blk_idx_o=blk, last_o=(blk==nblocks); outputs stable until out_ready_i.
REQ-013 OUT transfer: last -> IDLE; else blk<=blk+1, j<=1 -> REQ.
REQ-014 Latency: in transfer to first prf_valid_o = 1 cycle; PRF response to next prf_valid_o = 1 cycle; final response to out_valid_o = 1 cycle.
REQ-015 abort_i in REQ without same-cycle prf_ready_i, or in IDLE/OUT, SHALL go IDLE next cycle, no output beat; the PRF tolerates request withdrawal.
REQ-016 abort_i in WAIT, or in REQ with same-cycle prf_ready_i, SHALL go DRAIN: prf_ready_o=1, discard response, then IDLE.
REQ-017 abort_i SHALL override all other transitions in the same cycle; ignored in DRAIN.
REQ-018 prf_key_o SHALL equal registered pass at all times after acceptance.

Reset
REQ-019 rst_ni low SHALL asynchronously force IDLE; in_ready_o=1 after release; all other outputs 0; T, U, j, blk cleared.
REQ-020 Reset mid-job SHALL discard job; a PRF response after reset release SHALL be ignored (prf_ready_o=0 in IDLE).

Verification
REQ-021 P="password", S="salt", len 4, c=1, nblocks=1 -> msg 73616c7400000001, len 8; dk_o=120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b, last_o=1.
REQ-022 Same, c=2 -> two PRF requests, second len 32; dk_o=ae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43.
REQ-023 c=1, nblocks=2 -> two beats, blk_idx_o 1 then 2, last_o 0 then 1, second request index 00000002.
REQ-024 iters=0, or salt_len=61, or nblocks=0 -> one beat err_o=1, dk_o=0, zero prf_valid_o cycles.
REQ-025 abort_i in WAIT with PRF delaying 5 cycles -> DRAIN consumes response, IDLE, no out_valid_o; next job correct.
REQ-026 out_ready_i low 10 cycles, random prf_ready_i/prf_valid_i stalls -> outputs stable, results match REQ-021.
